// File: rtl/car_pkg.sv
// -----------------------------------------------------------------------------
// car_pkg
// Shared types and constants for the player-car controller and the sprite draw
// stage. The screen and sprite defaults live here so both blocks agree on the
// geometry.
//
// Contents:
//   POS_W / NXT_W / SPD_W / CNT_W : position, signed next-position, speed and
//                                   crash-counter widths
//   DEF_*                         : default screen, sprite and spawn constants
//   car_state_t                   : DRIVE / CRASH / RESPAWN
//   speed_up()                    : saturating +1 on the speed register
//   axis_next()                   : one-axis signed move (pos + dir*speed)
// -----------------------------------------------------------------------------
package car_pkg;

   localparam int POS_W = 12;
   // One extra bit so that a move past either screen edge stays representable
   // as a signed value and can be detected before clamping.
   localparam int NXT_W = POS_W + 1;
   localparam int SPD_W = 4;
   localparam int CNT_W = 8;

   localparam int DEF_SCREEN_W = 800;
   localparam int DEF_SCREEN_H = 600;
   localparam int DEF_CAR_W    = 48;
   localparam int DEF_CAR_H    = 64;
   localparam int DEF_X_INIT   = 376;
   localparam int DEF_Y_INIT   = 500;

   typedef enum logic [1:0] {
      DRIVE   = 2'd0,
      CRASH   = 2'd1,
      RESPAWN = 2'd2
   } car_state_t;

   // Saturating increment: speed never exceeds max_spd.
   function automatic logic [SPD_W-1:0] speed_up(
      input logic [SPD_W-1:0] spd,
      input logic [SPD_W-1:0] max_spd
   );
      logic [SPD_W:0] inc;
      logic [SPD_W-1:0] res;
      inc = {1'b0, spd} + (SPD_W+1)'(1);
      if (inc > {1'b0, max_spd}) begin
         res = max_spd;
      end else begin
         res = inc[SPD_W-1:0];
      end
      return res;
   endfunction

   // dir is +1 (2'b01), -1 (2'b11) or 0; the result is signed so that moves
   // below zero show up as negative values.
   function automatic logic signed [NXT_W-1:0] axis_next(
      input logic [POS_W-1:0]  pos,
      input logic signed [1:0] dir,
      input logic [SPD_W-1:0]  spd
   );
      logic signed [NXT_W-1:0] p;
      logic signed [NXT_W-1:0] s;
      logic signed [NXT_W-1:0] r;
      p = signed'({1'b0, pos});
      s = signed'({{(NXT_W-SPD_W){1'b0}}, spd});
      case (dir)
         2'b01:   r = p + s;
         2'b11:   r = p - s;
         default: r = p;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/frame_tick.sv
// -----------------------------------------------------------------------------
// frame_tick
// Rising-edge detector on vsync, producing one single-cycle tick per frame.
// Holding vsync high does not retrigger; only a new low-to-high transition
// does. Shared by every per-frame block on the pixel clock.
//
// Ports:
//   pclk     in  pixel clock
//   rst      in  synchronous, active-high reset
//   vsync_in in  vsync from the timing chain
//   tick     out high for the one cycle in which vsync_in is high but was low
//                on the previous cycle
// -----------------------------------------------------------------------------
module frame_tick (
   input  logic pclk,
   input  logic rst,
   input  logic vsync_in,
   output logic tick
);

   logic r_vsync_d;

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_vsync_d <= 1'b0;
      end else begin
         r_vsync_d <= vsync_in;
      end
   end

   assign tick = vsync_in & ~r_vsync_d;

endmodule

// File: rtl/car_ctl.sv
// -----------------------------------------------------------------------------
// car_ctl
// Per-frame position controller for the player car sprite. Once per frame
// (vsync rising edge) it reads the four direction buttons, accelerates the
// car with a saturating speed, moves it and keeps it on screen. Outputs are
// registered and stay stable for the whole frame, so the draw stage can latch
// them any time while vsync is high.
//
// Build option:
//   CAR_CTL_CRASH_EN defined   : hitting a screen edge clamps the car, then a
//                                blinking CRASH period of CRASH_FRAMES frames
//                                and a RESPAWN at (X_INIT, Y_INIT).
//   CAR_CTL_CRASH_EN undefined : hitting an edge only clamps the position and
//                                zeroes the speed; left is tied to 0 and no
//                                crash counter or crash states exist.
//
// Parameters:
//   SCREEN_W, SCREEN_H : visible area in pixels
//   CAR_W, CAR_H       : sprite size (must match the draw stage)
//   X_INIT, Y_INIT     : reset / respawn position
//   MAX_SPEED          : top speed in pixels per frame per axis (1..15)
//   CRASH_FRAMES       : frames spent in CRASH (1..255)
//
// Ports:
//   pclk        in   pixel clock, the only clock
//   rst         in   synchronous, active-high reset
//   vsync_in    in   vsync from the timing chain
//   btn_up/down/left/right in  direction buttons, already synchronous to pclk
//   xpos        out  sprite left x (12 bits)
//   ypos        out  sprite top y (12 bits)
//   left        out  alternate appearance; blinks while crashed
// -----------------------------------------------------------------------------
module car_ctl
   import car_pkg::*;
#(
   parameter int SCREEN_W     = DEF_SCREEN_W,
   parameter int SCREEN_H     = DEF_SCREEN_H,
   parameter int CAR_W        = DEF_CAR_W,
   parameter int CAR_H        = DEF_CAR_H,
   parameter int X_INIT       = DEF_X_INIT,
   parameter int Y_INIT       = DEF_Y_INIT,
   parameter int MAX_SPEED    = 7,
   parameter int CRASH_FRAMES = 60
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             vsync_in,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_left,
   input  logic             btn_right,
   output logic [POS_W-1:0] xpos,
   output logic [POS_W-1:0] ypos,
   output logic             left
);

   // Highest legal top-left coordinate on each axis.
   localparam logic signed [NXT_W-1:0] X_MAX   = NXT_W'(SCREEN_W - CAR_W);
   localparam logic signed [NXT_W-1:0] Y_MAX   = NXT_W'(SCREEN_H - CAR_H);
   localparam logic [POS_W-1:0]        X_RST   = POS_W'(X_INIT);
   localparam logic [POS_W-1:0]        Y_RST   = POS_W'(Y_INIT);
   localparam logic [SPD_W-1:0]        SPD_MAX = SPD_W'(MAX_SPEED);

   if (MAX_SPEED < 1 || MAX_SPEED >= (1 << SPD_W) ||
       CRASH_FRAMES < 1 || CRASH_FRAMES >= (1 << CNT_W)) begin : g_bad_cfg
      $error("car_ctl: MAX_SPEED or CRASH_FRAMES out of range");
   end

   // ------------------------------------------------------------------------
   // Frame tick
   // ------------------------------------------------------------------------
   logic w_tick;

   frame_tick u_frame_tick (
      .pclk     (pclk),
      .rst      (rst),
      .vsync_in (vsync_in),
      .tick     (w_tick)
   );

   // ------------------------------------------------------------------------
   // Motion datapath (shared by both builds)
   // ------------------------------------------------------------------------
   logic [POS_W-1:0]        r_xpos;
   logic [POS_W-1:0]        r_ypos;
   logic [SPD_W-1:0]        r_speed;
   logic [POS_W-1:0]        w_xpos_next;
   logic [POS_W-1:0]        w_ypos_next;
   logic [SPD_W-1:0]        w_speed_next;

   logic signed [1:0]       w_dx;
   logic signed [1:0]       w_dy;
   logic                    w_moving;
   logic [SPD_W-1:0]        w_speed_new;
   logic signed [NXT_W-1:0] w_nx;
   logic signed [NXT_W-1:0] w_ny;
   logic                    w_x_lo;
   logic                    w_x_hi;
   logic                    w_y_lo;
   logic                    w_y_hi;
   logic                    w_hit;
   logic [POS_W-1:0]        w_x_fit;
   logic [POS_W-1:0]        w_y_fit;

   // Opposing buttons cancel to zero on that axis.
   always_comb begin
      w_dx = 2'sd0;
      w_dy = 2'sd0;
      if (btn_right && !btn_left) begin
         w_dx = 2'sd1;
      end else if (btn_left && !btn_right) begin
         w_dx = -2'sd1;
      end
      if (btn_down && !btn_up) begin
         w_dy = 2'sd1;
      end else if (btn_up && !btn_down) begin
         w_dy = -2'sd1;
      end
   end

   assign w_moving = (w_dx != 2'sd0) || (w_dy != 2'sd0);

   // The accelerated speed is applied to this frame's move; releasing all
   // buttons drops straight back to standstill.
   assign w_speed_new = w_moving ? speed_up(r_speed, SPD_MAX) : '0;

   assign w_nx = axis_next(r_xpos, w_dx, w_speed_new);
   assign w_ny = axis_next(r_ypos, w_dy, w_speed_new);

   // Sign bit flags a move past the top/left edge; landing exactly on 0 or
   // on the max bound is still legal.
   assign w_x_lo = w_nx[NXT_W-1];
   assign w_x_hi = !w_nx[NXT_W-1] && (w_nx > X_MAX);
   assign w_y_lo = w_ny[NXT_W-1];
   assign w_y_hi = !w_ny[NXT_W-1] && (w_ny > Y_MAX);
   assign w_hit  = w_x_lo || w_x_hi || w_y_lo || w_y_hi;

   // Each axis is clamped to the bound it violated; an in-range axis keeps
   // its new value even when the other axis hits an edge.
   assign w_x_fit = w_x_lo ? '0 : (w_x_hi ? X_MAX[POS_W-1:0] : w_nx[POS_W-1:0]);
   assign w_y_fit = w_y_lo ? '0 : (w_y_hi ? Y_MAX[POS_W-1:0] : w_ny[POS_W-1:0]);

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_xpos  <= X_RST;
         r_ypos  <= Y_RST;
         r_speed <= '0;
      end else begin
         r_xpos  <= w_xpos_next;
         r_ypos  <= w_ypos_next;
         r_speed <= w_speed_next;
      end
   end

   assign xpos = r_xpos;
   assign ypos = r_ypos;

`ifdef CAR_CTL_CRASH_EN
   // ------------------------------------------------------------------------
   // DRIVE / CRASH / RESPAWN state machine
   // ------------------------------------------------------------------------
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CRASH_FRAMES);

   car_state_t       r_state;
   car_state_t       w_state_next;
   logic [CNT_W-1:0] r_crash_cnt;
   logic [CNT_W-1:0] w_crash_cnt_next;
   logic [CNT_W-1:0] w_cnt_dec;
   logic             r_left;
   logic             w_left_next;

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_state     <= DRIVE;
         r_crash_cnt <= '0;
         r_left      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_crash_cnt <= w_crash_cnt_next;
         r_left      <= w_left_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_crash_cnt_next = r_crash_cnt;
      w_left_next      = r_left;
      w_xpos_next      = r_xpos;
      w_ypos_next      = r_ypos;
      w_speed_next     = r_speed;
      w_cnt_dec        = r_crash_cnt - CNT_W'(1);

      if (w_tick) begin
         case (r_state)
            DRIVE: begin
               w_xpos_next = w_x_fit;
               w_ypos_next = w_y_fit;
               if (w_hit) begin
                  w_speed_next     = '0;
                  w_crash_cnt_next = CNT_INIT;
                  // left follows bit 3 of the counter from the first crash
                  // frame on, giving a 16-frame blink period.
                  w_left_next      = CNT_INIT[3];
                  w_state_next     = CRASH;
               end else begin
                  w_speed_next = w_speed_new;
               end
            end
            CRASH: begin
               // Position frozen, buttons ignored.
               w_crash_cnt_next = w_cnt_dec;
               w_left_next      = w_cnt_dec[3];
               if (w_cnt_dec == '0) begin
                  w_left_next  = 1'b0;
                  w_state_next = RESPAWN;
               end
            end
            RESPAWN: begin
               // Buttons ignored; the first move is on the following frame.
               w_xpos_next  = X_RST;
               w_ypos_next  = Y_RST;
               w_speed_next = '0;
               w_state_next = DRIVE;
            end
            default: begin
               w_state_next = DRIVE;
            end
         endcase
      end
   end

   assign left = r_left;
`else
   // ------------------------------------------------------------------------
   // Clamp-only build: an edge hit stops the car against the edge.
   // ------------------------------------------------------------------------
   always_comb begin
      w_xpos_next  = r_xpos;
      w_ypos_next  = r_ypos;
      w_speed_next = r_speed;
      if (w_tick) begin
         w_xpos_next  = w_x_fit;
         w_ypos_next  = w_y_fit;
         w_speed_next = w_hit ? '0 : w_speed_new;
      end
   end

   assign left = 1'b0;
`endif

endmodule

// File: tb/tb_car_ctl.sv
// -----------------------------------------------------------------------------
// tb_car_ctl
// Self-checking bench for car_ctl with default parameters. A short table of
// hand-derived frames covers acceleration and cancelling buttons; longer
// sequences (edge approach, crash/blink/respawn, exact landing on 0, vsync
// held high, reset mid-crash) use a small per-frame reference model. Every
// frame's expected outputs are queued when the buttons are driven and popped
// when the frame tick has updated the DUT.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_car_ctl;

   localparam logic [3:0] B_0 = 4'b0000;
   localparam logic [3:0] B_R = 4'b0001;
   localparam logic [3:0] B_L = 4'b0010;
   localparam logic [3:0] B_D = 4'b0100;
   localparam logic [3:0] B_U = 4'b1000;

   localparam int XLIM   = 752;
   localparam int YLIM   = 536;
   localparam int MAXS   = 7;
   localparam int CRASHF = 60;

`ifdef CAR_CTL_CRASH_EN
   localparam bit CRASH_ON = 1'b1;
`else
   localparam bit CRASH_ON = 1'b0;
`endif

   logic        pclk = 1'b0;
   logic        rst = 1'b1;
   logic        vsync_in = 1'b0;
   logic        btn_up = 1'b0;
   logic        btn_down = 1'b0;
   logic        btn_left = 1'b0;
   logic        btn_right = 1'b0;
   logic [11:0] xpos;
   logic [11:0] ypos;
   logic        left;

   car_ctl dut (
      .pclk      (pclk),
      .rst       (rst),
      .vsync_in  (vsync_in),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .xpos      (xpos),
      .ypos      (ypos),
      .left      (left)
   );

   always #5 pclk = ~pclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [3:0]  btn;
      logic [11:0] x;
      logic [11:0] y;
      logic        l;
   } vec_t;

   typedef struct {
      logic [11:0] x;
      logic [11:0] y;
      logic        l;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   frame_no = 0;

   // reference model state
   int m_x, m_y, m_spd, m_st, m_cnt;
   bit m_left;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
      end
   endtask

   task automatic model_reset();
      m_x = 376; m_y = 500; m_spd = 0; m_st = 0; m_cnt = 0; m_left = 1'b0;
   endtask

   // b = {up, down, left, right}
   task automatic model_step(input logic [3:0] b);
      int dx, dy, s, nx, ny;
      bit hit;
      dx = int'(b[0]) - int'(b[1]);
      dy = int'(b[2]) - int'(b[3]);
      case (m_st)
         0: begin
            if (dx == 0 && dy == 0) begin
               m_spd = 0;
            end else begin
               s  = (m_spd + 1 > MAXS) ? MAXS : m_spd + 1;
               nx = m_x + dx * s;
               ny = m_y + dy * s;
               hit = 1'b0;
               if (nx < 0)         begin nx = 0;    hit = 1'b1; end
               else if (nx > XLIM) begin nx = XLIM; hit = 1'b1; end
               if (ny < 0)         begin ny = 0;    hit = 1'b1; end
               else if (ny > YLIM) begin ny = YLIM; hit = 1'b1; end
               m_x = nx;
               m_y = ny;
               m_spd = hit ? 0 : s;
               if (hit && CRASH_ON) begin
                  m_st = 1;
                  m_cnt = CRASHF;
                  m_left = m_cnt[3];
               end
            end
         end
         1: begin
            m_cnt = m_cnt - 1;
            m_left = m_cnt[3];
            if (m_cnt == 0) m_st = 2;
         end
         default: begin
            m_x = 376; m_y = 500; m_spd = 0; m_st = 0;
         end
      endcase
   endtask

   task automatic check_out(input logic [3:0] b);
      exp_t e;
      frame_no++;
      $display("frame %0d btn(udlr)=%b xpos=%0d ypos=%0d left=%0d",
               frame_no, b, xpos, ypos, left);
      if (sb_q.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         e = sb_q.pop_front();
         chk($sformatf("frame%0d_xpos", frame_no), int'(xpos), int'(e.x));
         chk($sformatf("frame%0d_ypos", frame_no), int'(ypos), int'(e.y));
         chk($sformatf("frame%0d_left", frame_no), int'(left), int'(e.l));
      end
   endtask

   // One frame: buttons set, vsync rises, outputs checked one cycle later,
   // vsync stays high a while then drops.
   task automatic drive_frame(input logic [3:0] b);
      {btn_up, btn_down, btn_left, btn_right} = b;
      @(negedge pclk);
      vsync_in = 1'b1;
      @(negedge pclk);
      check_out(b);
      repeat (2) @(negedge pclk);
      vsync_in = 1'b0;
      repeat (3) @(negedge pclk);
   endtask

   task automatic model_frame(input logic [3:0] b);
      model_step(b);
      sb_q.push_back('{12'(m_x), 12'(m_y), m_left});
      drive_frame(b);
   endtask

   task automatic model_frames(input logic [3:0] b, input int n);
      for (int i = 0; i < n; i++) model_frame(b);
   endtask

   task automatic pulse_reset(input string nm);
      @(negedge pclk);
      rst = 1'b1;
      @(negedge pclk);
      chk({nm, "_xpos"}, int'(xpos), 376);
      chk({nm, "_ypos"}, int'(ypos), 500);
      chk({nm, "_left"}, int'(left), 0);
      rst = 1'b0;
      model_reset();
   endtask

   vec_t vecs[7];
   int   old_y;

   initial begin
      vecs[0] = '{B_R,       12'd377, 12'd500, 1'b0};
      vecs[1] = '{B_R,       12'd379, 12'd500, 1'b0};
      vecs[2] = '{B_R,       12'd382, 12'd500, 1'b0};
      vecs[3] = '{B_L | B_R, 12'd382, 12'd500, 1'b0};
      vecs[4] = '{B_L | B_R, 12'd382, 12'd500, 1'b0};
      vecs[5] = '{B_U,       12'd382, 12'd499, 1'b0};
      vecs[6] = '{B_0,       12'd382, 12'd499, 1'b0};

      // power-on reset
      repeat (3) @(negedge pclk);
      chk("reset_xpos", int'(xpos), 376);
      chk("reset_ypos", int'(ypos), 500);
      chk("reset_left", int'(left), 0);
      rst = 1'b0;
      model_reset();
      repeat (2) @(negedge pclk);

      // acceleration, cancelling buttons, speed back to zero
      for (int i = 0; i < 7; i++) begin
         model_step(vecs[i].btn);
         sb_q.push_back('{vecs[i].x, vecs[i].y, vecs[i].l});
         drive_frame(vecs[i].btn);
      end

      // approach x = 750 in bursts, then run into the right edge
      model_frames(B_R, 55);
      model_frame(B_0);
      model_frames(B_R, 2);
      model_frame(B_0);
      model_frame(B_R);
      chk("approach_x750", int'(xpos), 750);
      model_frame(B_R);
      model_frame(B_R);
      chk("edge_clamp_x", int'(xpos), 752);
      chk("edge_left", int'(left), CRASH_ON ? 1 : 0);

      // crash period with buttons held (ignored), then respawn
      model_frames(B_R, CRASHF);
      model_frame(B_R);
      chk("respawn_x", int'(xpos), CRASH_ON ? 376 : 752);
      chk("respawn_y", int'(ypos), CRASH_ON ? 500 : 499);
      chk("respawn_left", int'(left), 0);
      model_frame(B_R);
      chk("first_move_x", int'(xpos), CRASH_ON ? 377 : 752);

      // land exactly on y = 0, then push through the top edge
      pulse_reset("reset2");
      model_frame(B_0);
      model_frames(B_U, 2);
      model_frame(B_0);
      model_frames(B_U, 74);
      chk("exact_y0", int'(ypos), 0);
      chk("exact_y0_left", int'(left), 0);
      model_frame(B_U);
      chk("top_clamp_y", int'(ypos), 0);
      chk("top_crash_left", int'(left), CRASH_ON ? 1 : 0);
      model_frames(B_0, 2);

      // reset in the middle of the crash blink
      pulse_reset("reset_mid_crash");
      model_frame(B_D);
      chk("after_reset_move_y", int'(ypos), 501);
      model_frame(B_0);

      // vsync held high: exactly one move
      old_y = m_y;
      model_step(B_D);
      {btn_up, btn_down, btn_left, btn_right} = B_D;
      @(negedge pclk);
      vsync_in = 1'b1;
      #1;
      chk("hold_pre_tick_y", int'(ypos), old_y);
      @(negedge pclk);
      chk("hold_tick_y", int'(ypos), old_y + 1);
      repeat (80) @(negedge pclk);
      chk("hold_no_repeat_y", int'(ypos), old_y + 1);
      vsync_in = 1'b0;
      repeat (4) @(negedge pclk);
      chk("hold_fall_y", int'(ypos), m_y);
      $display("frame hold btn(udlr)=%b xpos=%0d ypos=%0d left=%0d", B_D, xpos, ypos, left);
      {btn_up, btn_down, btn_left, btn_right} = B_0;

      chk("scoreboard_drained", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
